// File: rtl/lut_loader_pkg.sv
// Shared constants and FSM encoding for the LUT6 equation loader.
package lut_loader_pkg;

    localparam int LUT_BITS   = 64;
    localparam int LUT_ADDR_W = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WRITE  = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/lut_we_decoder.sv
// One-hot write-enable decode for the LUT bank, with a range check on the id.
module lut_we_decoder #(
    parameter int NUM_LUTS = 32,
    parameter int ID_W     = 5
) (
    input  logic [ID_W-1:0]     id,
    input  logic                en,
    output logic [NUM_LUTS-1:0] we,
    output logic                id_ok
);

    localparam logic [NUM_LUTS-1:0] ONE = {{(NUM_LUTS-1){1'b0}}, 1'b1};

    assign id_ok = (int'(id) < NUM_LUTS);

    // Out-of-range ids decode to all-zero so no cell is ever touched.
    always_comb begin
        we = '0;
        if (en && id_ok) begin
            we = ONE << id;
        end
    end

endmodule

// File: rtl/lut_equation_loader.sv
// Serial writer for a bank of LUT6 cells: one equation bit per cycle, with
// an optional read-back pass that flags any bit that did not stick.
module lut_equation_loader
    import lut_loader_pkg::*;
#(
    parameter int NUM_LUTS = 32,
    parameter int ID_W     = 5,
    parameter int VERIFY   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_W-1:0]       in_lut_id,
    input  logic [LUT_BITS-1:0]   in_equation,
    output logic [NUM_LUTS-1:0]   lut_we,
    output logic                  lut_data,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [NUM_LUTS-1:0]   lut_q,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [LUT_ADDR_W-1:0] LAST_ADDR = LUT_ADDR_W'(LUT_BITS - 1);

    state_t                  state;
    logic [ID_W-1:0]         id_q;
    logic [LUT_BITS-1:0]     eq_q;
    logic                    miss_q;

    logic                    accept;
    logic                    id_ok;
    logic [NUM_LUTS-1:0]     dec_we;
    logic [LUT_ADDR_W-1:0]   next_addr;
    logic [NUM_LUTS-1:0]     q_sh;
    logic                    rd_miss;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign next_addr = lut_addr + 1'b1;

    // Read-back selects the target cell by shifting rather than indexing,
    // so ID_W may be wider than the bank index.
    assign q_sh    = lut_q >> id_q;
    assign rd_miss = (q_sh[0] != eq_q[lut_addr]);

    lut_we_decoder #(
        .NUM_LUTS (NUM_LUTS),
        .ID_W     (ID_W)
    ) u_we_decoder (
        .id    (in_lut_id),
        .en    (accept),
        .we    (dec_we),
        .id_ok (id_ok)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            id_q     <= '0;
            eq_q     <= '0;
            miss_q   <= 1'b0;
            lut_we   <= '0;
            lut_data <= 1'b0;
            lut_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q     <= in_lut_id;
                        eq_q     <= in_equation;
                        miss_q   <= 1'b0;
                        busy     <= 1'b1;
                        lut_addr <= '0;
                        if (id_ok) begin
                            state    <= ST_WRITE;
                            lut_we   <= dec_we;
                            lut_data <= in_equation[0];
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    lut_addr <= next_addr;
                    if (lut_addr == LAST_ADDR) begin
                        lut_we   <= '0;
                        lut_data <= 1'b0;
                        if (VERIFY != 0) begin
                            state <= ST_VERIFY;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        lut_data <= eq_q[next_addr];
                    end
                end
                ST_VERIFY: begin
                    lut_addr <= next_addr;
                    miss_q   <= miss_q | rd_miss;
                    // The final compare is folded straight into error.
                    if (lut_addr == LAST_ADDR) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        error <= miss_q | rd_miss;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_equation_loader.sv
// Bench for lut_equation_loader: model LUT bank, expectation queue and done monitor.
module tb_lut_equation_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bank_clr = 1'b1;
    logic        stuck = 1'b0;

    always #5 clock = ~clock;

    // Main instance: VERIFY=1, ID_W=6 so out-of-range ids can be driven.
    logic        in_valid;
    logic [5:0]  in_lut_id;
    logic [63:0] in_equation;
    logic        in_ready;
    logic [31:0] lut_we;
    logic        lut_data;
    logic [5:0]  lut_addr;
    logic [31:0] lut_q;
    logic        busy, done, error;

    // Second instance: VERIFY=0.
    logic        v0;
    logic [4:0]  id0;
    logic [63:0] eq0;
    logic        rdy0;
    logic [31:0] we0;
    logic        data0;
    logic [5:0]  addr0;
    logic [31:0] q0;
    logic        busy0, done0, error0;

    lut_equation_loader #(.NUM_LUTS(32), .ID_W(6), .VERIFY(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lut_id(in_lut_id), .in_equation(in_equation), .lut_we(lut_we),
        .lut_data(lut_data), .lut_addr(lut_addr), .lut_q(lut_q),
        .busy(busy), .done(done), .error(error)
    );

    lut_equation_loader #(.NUM_LUTS(32), .ID_W(5), .VERIFY(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(v0), .in_ready(rdy0),
        .in_lut_id(id0), .in_equation(eq0), .lut_we(we0),
        .lut_data(data0), .lut_addr(addr0), .lut_q(q0),
        .busy(busy0), .done(done0), .error(error0)
    );

    // Model LUT banks: synchronous write, asynchronous read.
    logic [63:0] bank  [32];
    logic [63:0] bank0 [32];

    always @(posedge clock) begin
        for (int i = 0; i < 32; i++) begin
            if (bank_clr) begin
                bank[i]  <= '0;
                bank0[i] <= '0;
            end else begin
                if (lut_we[i])
                    bank[i][lut_addr] <= (stuck && i == 5 && lut_addr == 6'd17) ? 1'b0 : lut_data;
                if (we0[i])
                    bank0[i][addr0] <= data0;
            end
        end
    end

    always_comb begin
        lut_q = '0;
        q0    = '0;
        for (int i = 0; i < 32; i++) begin
            lut_q[i] = bank[i][lut_addr];
            q0[i]    = bank0[i][addr0];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: expectations pushed by the driver, accept cycles logged at the edge.
    typedef struct {
        logic  err;
        int    lat;
        string name;
    } exp_t;

    exp_t expq[$];
    int   accq[$];
    int   cyc   = 0;
    int   dones = 0;

    always @(posedge clock) begin
        if (!reset && in_valid && in_ready)
            accq.push_back(cyc);
        cyc++;
    end

    always @(negedge clock) begin
        if (!reset && done) begin
            dones++;
            if (expq.size() == 0 || accq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                exp_t e;
                int   a;
                e = expq.pop_front();
                a = accq.pop_front();
                chk({e.name, "_err"}, error, e.err);
                chk({e.name, "_lat"}, cyc - a, e.lat);
                chk({e.name, "_rdy_in_done"}, in_ready, 0);
            end
        end
        if (!reset && lut_we != 0)
            chk("we_onehot", $countones(lut_we), 1);
    end

    task automatic load(input logic [5:0] id, input logic [63:0] eq, input logic err,
                        input int lat, input string nm, input bit push);
        int n;
        in_valid    = 1'b1;
        in_lut_id   = id;
        in_equation = eq;
        if (push) begin
            exp_t e;
            e.err  = err;
            e.lat  = lat;
            e.name = nm;
            expq.push_back(e);
        end
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clock);
            chk({nm, "_rdy_low_busy"}, in_ready, !busy);
            n++;
        end
        chk({nm, "_accept_timeout"}, n < 400, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_sb(input string nm);
        int n;
        n = 0;
        while ((expq.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_drain_timeout"}, n < 400, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] eq;
        int d0;

        in_valid = 0; in_lut_id = 0; in_equation = 0;
        v0 = 0; id0 = 0; eq0 = 0;
        repeat (3) @(negedge clock);
        chk("rst_we", lut_we, 0);
        chk("rst_addr", lut_addr, 0);
        chk("rst_data", lut_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", in_ready, 1);
        reset = 0;
        bank_clr = 0;
        @(negedge clock);

        // Basic write + verify into LUT3.
        eq = 64'hDEAD_BEEF_0123_4567;
        load(6'd3, eq, 1'b0, 129, "basic", 1);
        in_valid = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            chk("basic_we", lut_we, 32'h8);
            chk("basic_addr", lut_addr, k);
            chk("basic_data", lut_data, eq[k]);
        end
        @(negedge clock);
        chk("basic_we_off", lut_we, 0);
        wait_sb("basic");
        chk("basic_bank3", bank[3], eq);

        // Out-of-range id.
        load(6'd40, 64'h5555_5555_5555_5555, 1'b1, 1, "badid", 1);
        in_valid = 0;
        @(negedge clock);
        chk("badid_we", lut_we, 0);
        chk("badid_done", done, 1);
        @(negedge clock);
        chk("badid_ready_back", in_ready, 1);
        chk("badid_done_off", done, 0);
        wait_sb("badid");

        // Stuck-at-0 bit 17 in LUT5 must be caught by read-back.
        stuck = 1;
        load(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 129, "vfail", 1);
        in_valid = 0;
        wait_sb("vfail");
        stuck = 0;
        chk("vfail_bank5", bank[5], 64'hFFFF_FFFF_FFFD_FFFF);

        // Three words with in_valid held high throughout.
        d0 = dones;
        load(6'd1, 64'h0123_4567_89AB_CDEF, 1'b0, 129, "b2b0", 1);
        load(6'd2, 64'hF0F0_0F0F_A5A5_5A5A, 1'b0, 129, "b2b1", 1);
        load(6'd4, 64'h8000_0000_0000_0001, 1'b0, 129, "b2b2", 1);
        in_valid = 0;
        wait_sb("b2b");
        chk("b2b_done_count", dones - d0, 3);
        chk("b2b_bank1", bank[1], 64'h0123_4567_89AB_CDEF);
        chk("b2b_bank2", bank[2], 64'hF0F0_0F0F_A5A5_5A5A);
        chk("b2b_bank4", bank[4], 64'h8000_0000_0000_0001);

        // Reset after 20 write edges: partial write survives, no done.
        load(6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "rstmid", 0);
        in_valid = 0;
        repeat (20) @(posedge clock);
        #1 reset = 1;
        #1;
        chk("rstmid_we", lut_we, 0);
        chk("rstmid_addr", lut_addr, 0);
        chk("rstmid_data", lut_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_error", error, 0);
        @(negedge clock);
        expq.delete();
        accq.delete();
        @(negedge clock);
        reset = 0;
        repeat (3) @(negedge clock);
        chk("rstmid_bank7", bank[7], 64'h0000_0000_000F_FFFF);
        chk("rstmid_idle", in_ready, 1);

        // VERIFY=0 instance: eq=1 into LUT0, done 65 cycles after accept.
        chk("nv_ready", rdy0, 1);
        v0 = 1; id0 = 5'd0; eq0 = 64'h1;
        @(posedge clock);
        #1 v0 = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            chk("nv_we", we0, 32'h1);
            chk("nv_addr", addr0, k);
            chk("nv_data", data0, (k == 0) ? 1 : 0);
            chk("nv_done_early", done0, 0);
        end
        @(negedge clock);
        chk("nv_done", done0, 1);
        chk("nv_error", error0, 0);
        chk("nv_we_off", we0, 0);
        @(negedge clock);
        chk("nv_done_pulse", done0, 0);
        chk("nv_ready_back", rdy0, 1);
        chk("nv_bank0", bank0[0], 64'h1);

        chk("final_expq_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
